fp8_vec_mult: RTL and testbench

Pipelined, parametrised FP8 vector multiplier. It is the successor to the scalar E5M2 multiplier and adds the following:
- NUM_LANES parallel lanes.
- Per-beat format select between E5M2 and E4M3 (OCP FP8).
- Full subnormal handling with round-to-nearest-even.
- A valid/ready streaming handshake.

It feeds the tensor-core PE accumulator and sits between the operand broadcast network and the adder tree.

---
 rtl/fp8_pkg.sv | 48 ++++
 rtl/fp8_mul_lane.sv | 154 +++++++++++++++
 rtl/fp8_vec_mult.sv | 106 ++++++++++
 tb/tb_fp8_vec_mult.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// fp8_pkg: shared types and constants for the FP8 vector multiplier.
//   fmt_e      beat format (E5M2 / E4M3)
//   cls_e      per-lane special-case class carried from S1 to S2
//   lane_s1_t  per-lane S1 pipeline payload
//   lzc8       leading-zero count of the 8-bit significand product
package fp8_pkg;

   typedef enum logic {FMT_E5M2 = 1'b0, FMT_E4M3 = 1'b1} fmt_e;

   typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

   localparam int E5M2_EXP_W = 5;
   localparam int E5M2_MAN_W = 2;
   localparam int E5M2_BIAS  = 15;
   localparam int E4M3_EXP_W = 4;
   localparam int E4M3_MAN_W = 3;
   localparam int E4M3_BIAS  = 7;

   localparam logic [7:0] E5M2_NAN = 8'h7E;
   localparam logic [7:0] E4M3_NAN = 8'h7F;
   localparam logic [7:0] E5M2_MAX = 8'h7B;
   localparam logic [7:0] E4M3_MAX = 8'h7E;
   localparam logic [7:0] E5M2_INF = 8'h7C;

   // prod: significand product, 2 integer + 6 fraction bits for both formats
   // exp:  biased result exponent before normalisation
   typedef struct packed {
      logic              sign;
      cls_e              cls;
      logic [7:0]        prod;
      logic signed [6:0] exp;
   } lane_s1_t;

   function automatic logic [2:0] lzc8(input logic [7:0] v);
      logic [2:0] n;
      logic       found;
      n     = 3'd0;
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n     = n + 3'd1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fp8_mul_lane.sv
// fp8_mul_lane: combinational logic of one multiplier lane.
//   S1 side: s1_mode_i, a_i, b_i -> s1_o (decode, class, significand product, exponent)
//   S2 side: s2_mode_i, s2_i     -> c_o, nan_o, inf_o, ovf_o, unf_o (normalise, RNE, overflow)
// Build option: FP8_MULT_SAT_EN makes finite overflow saturate to +/-max normal.
module fp8_mul_lane
   import fp8_pkg::*;
(
   input  fmt_e       s1_mode_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output lane_s1_t   s1_o,
   input  fmt_e       s2_mode_i,
   input  lane_s1_t   s2_i,
   output logic [7:0] c_o,
   output logic       nan_o,
   output logic       inf_o,
   output logic       ovf_o,
   output logic       unf_o
);

   logic [4:0]        ea, eb, ea_eff, eb_eff;
   logic [2:0]        fa, fb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic signed [6:0] bias;

   // E5M2 fractions are padded to 3 bits so both formats share one 4x4 multiplier
   // and one fixed-point position in the product.
   always_comb begin
      if (s1_mode_i == FMT_E5M2) begin
         ea    = a_i[6 -: E5M2_EXP_W];
         eb    = b_i[6 -: E5M2_EXP_W];
         fa    = {a_i[E5M2_MAN_W-1:0], 1'b0};
         fb    = {b_i[E5M2_MAN_W-1:0], 1'b0};
         a_nan = (&ea) && (|a_i[E5M2_MAN_W-1:0]);
         b_nan = (&eb) && (|b_i[E5M2_MAN_W-1:0]);
         a_inf = (&ea) && !(|a_i[E5M2_MAN_W-1:0]);
         b_inf = (&eb) && !(|b_i[E5M2_MAN_W-1:0]);
         bias  = 7'(E5M2_BIAS);
      end else begin
         ea    = {1'b0, a_i[6 -: E4M3_EXP_W]};
         eb    = {1'b0, b_i[6 -: E4M3_EXP_W]};
         fa    = a_i[E4M3_MAN_W-1:0];
         fb    = b_i[E4M3_MAN_W-1:0];
         a_nan = &a_i[6:0];
         b_nan = &b_i[6:0];
         a_inf = 1'b0;
         b_inf = 1'b0;
         bias  = 7'(E4M3_BIAS);
      end
      a_zero = (ea == 5'd0) && (fa == 3'd0);
      b_zero = (eb == 5'd0) && (fb == 3'd0);
      ea_eff = (ea == 5'd0) ? 5'd1 : ea;
      eb_eff = (eb == 5'd0) ? 5'd1 : eb;

      s1_o.sign = a_i[7] ^ b_i[7];
      s1_o.prod = 8'({(ea != 5'd0), fa}) * 8'({(eb != 5'd0), fb});
      s1_o.exp  = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - bias;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) s1_o.cls = CLS_NAN;
      else if (a_inf || b_inf)                                      s1_o.cls = CLS_INF;
      else if (a_zero || b_zero)                                    s1_o.cls = CLS_ZERO;
      else                                                          s1_o.cls = CLS_NORM;
   end

   logic [2:0]        lz;
   logic [7:0]        norm;
   logic signed [7:0] exp_n;
   logic [7:0]        sh;
   logic [31:0]       w;
   logic              tiny;
   logic [6:0]        exp_f, exp_r;
   logic [9:0]        enc;
   logic [2:0]        man_r;
   logic              g, r, st, inc, ovf;
   logic              unused_hidden;

   always_comb begin
      lz    = lzc8(s2_i.prod);
      norm  = s2_i.prod << lz;
      // Leading one at bit 7 of norm means value in [1,2) at exponent exp_n.
      exp_n = $signed({s2_i.exp[6], s2_i.exp}) + 8'sd1 - $signed({5'b00000, lz});
      tiny  = (exp_n <= 8'sd0);
      sh    = tiny ? 8'(8'sd1 - exp_n) : 8'd0;
      // 24 bits of headroom keep every shifted-out bit visible to the sticky OR.
      w     = {norm, 24'd0} >> sh;
      exp_f = tiny ? 7'd0 : exp_n[6:0];
      unused_hidden = w[31];

      // Adding the round increment to {exp, mant} lets a mantissa carry bump the
      // exponent, and turns a subnormal carry into min normal without extra cases.
      if (s2_mode_i == FMT_E5M2) begin
         g     = w[28];
         r     = w[27];
         st    = |w[26:0];
         inc   = g & (r | st | w[29]);
         enc   = {1'b0, exp_f, w[30:29]} + 10'(inc);
         exp_r = enc[8:2];
         man_r = {1'b0, enc[1:0]};
         ovf   = (exp_r >= 7'd31);
      end else begin
         g     = w[27];
         r     = w[26];
         st    = |w[25:0];
         inc   = g & (r | st | w[28]);
         enc   = {exp_f, w[30:28]} + 10'(inc);
         exp_r = enc[9:3];
         man_r = enc[2:0];
         // S.1111.111 is the NaN code, so anything at or above it is out of range.
         ovf   = (exp_r > 7'd15) || ((exp_r == 7'd15) && (man_r == 3'd7));
      end

      c_o   = 8'd0;
      nan_o = 1'b0;
      inf_o = 1'b0;
      ovf_o = 1'b0;
      unf_o = 1'b0;
      unique case (s2_i.cls)
         CLS_NAN: begin
            c_o   = (s2_mode_i == FMT_E5M2) ? E5M2_NAN : E4M3_NAN;
            nan_o = 1'b1;
         end
         CLS_INF: begin
            c_o   = {s2_i.sign, E5M2_INF[6:0]};
            inf_o = 1'b1;
         end
         CLS_ZERO: begin
            c_o = {s2_i.sign, 7'd0};
         end
         default: begin
            if (ovf) begin
               ovf_o = 1'b1;
`ifdef FP8_MULT_SAT_EN
               c_o = (s2_mode_i == FMT_E5M2) ? {s2_i.sign, E5M2_MAX[6:0]}
                                             : {s2_i.sign, E4M3_MAX[6:0]};
`else
               if (s2_mode_i == FMT_E5M2) begin
                  c_o   = {s2_i.sign, E5M2_INF[6:0]};
                  inf_o = 1'b1;
               end else begin
                  c_o   = E4M3_NAN;
                  nan_o = 1'b1;
               end
`endif
            end else begin
               c_o   = (s2_mode_i == FMT_E5M2) ? {s2_i.sign, exp_r[4:0], man_r[1:0]}
                                               : {s2_i.sign, exp_r[3:0], man_r[2:0]};
               // Tininess is judged before rounding, so a subnormal that rounds
               // up to min normal still reports underflow when inexact.
               unf_o = tiny & (g | r | st);
            end
         end
      endcase
   end

endmodule

// File: rtl/fp8_vec_mult.sv
// fp8_vec_mult: two-stage pipelined FP8 (E5M2/E4M3) vector multiplier.
//   clk_i, rst_i (sync, active-high)
//   in_valid_i/in_ready_o, mode_i, a_i, b_i     : input beat, NUM_LANES x 8 bits
//   out_valid_o/out_ready_i, c_o, nan_o, inf_o,
//   ovf_o, unf_o                                : result beat and per-lane flags
// Build option: FP8_MULT_SAT_EN (see fp8_mul_lane) selects saturating overflow.
module fp8_vec_mult
   import fp8_pkg::*;
#(
   parameter int NUM_LANES = 4
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   mode_i,
   input  logic [8*NUM_LANES-1:0] a_i,
   input  logic [8*NUM_LANES-1:0] b_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [8*NUM_LANES-1:0] c_o,
   output logic [NUM_LANES-1:0]   nan_o,
   output logic [NUM_LANES-1:0]   inf_o,
   output logic [NUM_LANES-1:0]   ovf_o,
   output logic [NUM_LANES-1:0]   unf_o
);

   logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   fmt_e                   s1_mode_q, s1_mode_d;
   lane_s1_t               s1_lane_c [NUM_LANES];
   lane_s1_t               s1_lane_q [NUM_LANES];
   lane_s1_t               s1_lane_d [NUM_LANES];
   logic [8*NUM_LANES-1:0] c_c, c_q, c_d;
   logic [NUM_LANES-1:0]   nan_c, inf_c, ovf_c, unf_c;
   logic [NUM_LANES-1:0]   nan_q, inf_q, ovf_q, unf_q;
   logic [NUM_LANES-1:0]   nan_d, inf_d, ovf_d, unf_d;
   logic                   s1_ready, s2_ready, in_fire, s1_fire;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      fp8_mul_lane u_lane (
         .s1_mode_i (fmt_e'(mode_i)),
         .a_i       (a_i[8*k +: 8]),
         .b_i       (b_i[8*k +: 8]),
         .s1_o      (s1_lane_c[k]),
         .s2_mode_i (s1_mode_q),
         .s2_i      (s1_lane_q[k]),
         .c_o       (c_c[8*k +: 8]),
         .nan_o     (nan_c[k]),
         .inf_o     (inf_c[k]),
         .ovf_o     (ovf_c[k]),
         .unf_o     (unf_c[k])
      );
   end

   // A stage may load when it is empty or its contents leave in the same cycle.
   always_comb begin
      s2_ready   = !s2_valid_q || out_ready_i;
      s1_ready   = !s1_valid_q || s2_ready;
      in_fire    = in_valid_i && s1_ready;
      s1_fire    = s1_valid_q && s2_ready;
      s1_valid_d = s1_ready ? in_valid_i : s1_valid_q;
      s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
      s1_mode_d  = in_fire ? fmt_e'(mode_i) : s1_mode_q;
      for (int k = 0; k < NUM_LANES; k++) begin
         s1_lane_d[k] = in_fire ? s1_lane_c[k] : s1_lane_q[k];
      end
      c_d   = s1_fire ? c_c   : c_q;
      nan_d = s1_fire ? nan_c : nan_q;
      inf_d = s1_fire ? inf_c : inf_q;
      ovf_d = s1_fire ? ovf_c : ovf_q;
      unf_d = s1_fire ? unf_c : unf_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_mode_q  <= FMT_E5M2;
         for (int k = 0; k < NUM_LANES; k++) s1_lane_q[k] <= '0;
         c_q   <= '0;
         nan_q <= '0;
         inf_q <= '0;
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_mode_q  <= s1_mode_d;
         for (int k = 0; k < NUM_LANES; k++) s1_lane_q[k] <= s1_lane_d[k];
         c_q   <= c_d;
         nan_q <= nan_d;
         inf_q <= inf_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign in_ready_o  = s1_ready;
   assign out_valid_o = s2_valid_q;
   assign c_o         = c_q;
   assign nan_o       = nan_q;
   assign inf_o       = inf_q;
   assign ovf_o       = ovf_q;
   assign unf_o       = unf_q;

endmodule

// File: tb/tb_fp8_vec_mult.sv
// tb_fp8_vec_mult: directed-vector bench for fp8_vec_mult with NUM_LANES = 4.
// Lane k of every 32-bit vector sits at [8k+7:8k]; flag vectors are {lane3..lane0}.
module tb_fp8_vec_mult;

`ifdef FP8_MULT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i, in_valid_i, in_ready_o, mode_i, out_valid_o, out_ready_i;
   logic [31:0] a_i, b_i, c_o;
   logic [3:0]  nan_o, inf_o, ovf_o, unf_o;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk_i = ~clk_i;

   fp8_vec_mult #(.NUM_LANES(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .mode_i      (mode_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .c_o         (c_o),
      .nan_o       (nan_o),
      .inf_o       (inf_o),
      .ovf_o       (ovf_o),
      .unf_o       (unf_o)
   );

   // Sends one beat into an idle pipeline and returns the first result beat.
   // lat counts cycles from the accept cycle; -1 means no result within the budget.
   task automatic run_beat(input logic m, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] c, output logic [15:0] flags, output int lat);
      c     = 'x;
      flags = 'x;
      lat   = -1;
      @(negedge clk_i);
      mode_i = m; a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (out_valid_o && lat < 0) begin
            lat   = i;
            c     = c_o;
            flags = {nan_o, inf_o, ovf_o, unf_o};
         end
         if (lat < 0) @(negedge clk_i);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; mode_i = 1'b0; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
      n_cmp++;
      if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
      n_cmp++;
      if ({c_o, nan_o, inf_o, ovf_o, unf_o} !== 48'd0)
         begin n_bad++; $display("FAIL reset_outputs got c=%h flags=%h want 0", c_o, {nan_o, inf_o, ovf_o, unf_o}); end
   endtask

   task automatic test_e5m2_basic();
      logic [31:0] c; logic [15:0] f; int lat;
      // 1.5*1.5 tie -> 2.0 ; 1*1 ; -1*2 ; +0 * -0 -> -0
      run_beat(1'b0, 32'h00BC3C3E, 32'h80403C3E, c, f, lat);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL e5m2_latency got %0d want 2", lat); end
      n_cmp++;
      if (c !== 32'h80C03C40) begin n_bad++; $display("FAIL e5m2_basic_c got %h want 80c03c40", c); end
      n_cmp++;
      if (f !== 16'h0000) begin n_bad++; $display("FAIL e5m2_basic_flags got %h want 0000", f); end
   endtask

   task automatic test_specials();
      logic [31:0] c; logic [15:0] f; int lat;
      logic [31:0] exp_c; logic [15:0] exp_f;
      // inf*0 ; -inf*1 ; NaN*1 ; max*max overflow
      exp_c = SAT ? 32'h7B7EFC7E : 32'h7C7EFC7E;
      exp_f = {4'b0101, (SAT ? 4'b0010 : 4'b1010), 4'b1000, 4'b0000};
      run_beat(1'b0, 32'h7B7DFC7C, 32'h7B3C3C00, c, f, lat);
      n_cmp++;
      if (c !== exp_c) begin n_bad++; $display("FAIL specials_c got %h want %h", c, exp_c); end
      n_cmp++;
      if (f !== exp_f) begin n_bad++; $display("FAIL specials_flags got %h want %h", f, exp_f); end
   endtask

   task automatic test_subnormals();
      logic [31:0] c; logic [15:0] f; int lat;
      // 2^-16*1 exact ; 2^-17 tie -> 0 ; 0.9375*2^-14 -> min normal ; -2^-16
      run_beat(1'b0, 32'h81030101, 32'h3C3D383C, c, f, lat);
      n_cmp++;
      if (c !== 32'h81040001) begin n_bad++; $display("FAIL subn_a_c got %h want 81040001", c); end
      n_cmp++;
      if (f !== 16'h0006) begin n_bad++; $display("FAIL subn_a_flags got %h want 0006", f); end
      // 2^-32 -> 0 ; min normal*0.5 exact subnormal ; inexact normal 1.3125 -> 1.25 ; 0.75*2^-14 exact
      run_beat(1'b0, 32'h02070401, 32'h3E3A3801, c, f, lat);
      n_cmp++;
      if (c !== 32'h03050200) begin n_bad++; $display("FAIL subn_b_c got %h want 03050200", c); end
      n_cmp++;
      if (f !== 16'h0001) begin n_bad++; $display("FAIL subn_b_flags got %h want 0001", f); end
   endtask

   task automatic test_e4m3();
      logic [31:0] c; logic [15:0] f; int lat;
      logic [31:0] exp_c; logic [15:0] exp_f;
      // 448*2 overflow ; 448*1 boundary ; NaN*1 ; -1.125*1.5 rounds to -1.75
      exp_c = SAT ? 32'hBE7F7E7E : 32'hBE7F7E7F;
      exp_f = {(SAT ? 4'b0100 : 4'b0101), 4'b0000, 4'b0001, 4'b0000};
      run_beat(1'b1, 32'hB97F7E7E, 32'h3C383840, c, f, lat);
      n_cmp++;
      if (c !== exp_c) begin n_bad++; $display("FAIL e4m3_a_c got %h want %h", c, exp_c); end
      n_cmp++;
      if (f !== exp_f) begin n_bad++; $display("FAIL e4m3_a_flags got %h want %h", f, exp_f); end
      // 416*1.125 rounds past 448 ; 2^-9*1 ; 2^-10 tie -> 0 ; 2^-6 * -1
      exp_c = SAT ? 32'h8800017E : 32'h8800017F;
      exp_f = {(SAT ? 4'b0000 : 4'b0001), 4'b0000, 4'b0001, 4'b0100};
      run_beat(1'b1, 32'h0801017D, 32'hB8303839, c, f, lat);
      n_cmp++;
      if (c !== exp_c) begin n_bad++; $display("FAIL e4m3_b_c got %h want %h", c, exp_c); end
      n_cmp++;
      if (f !== exp_f) begin n_bad++; $display("FAIL e4m3_b_flags got %h want %h", f, exp_f); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ba[5], bb[5], bc[5];
      logic        bm[5];
      int          acc, got, acc_stall;
      logic        rdy_c2;
      ba = '{32'h3C3C3C3E, 32'h38383838, 32'h40404040, 32'h48484848, 32'hBCBCBCBC};
      bb = '{32'h403C3C3E, 32'h40384038, 32'h44444444, 32'h38383838, 32'h3C3C3C3C};
      bc = '{32'h403C3C40, 32'h40384038, 32'h48484848, 32'h48484848, 32'hBCBCBCBC};
      bm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      acc = 0; got = 0; acc_stall = -1; rdy_c2 = 1'bx;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         @(negedge clk_i);
         out_ready_i = (cyc >= 4);
         if (acc < 5) begin
            in_valid_i = 1'b1; mode_i = bm[acc]; a_i = ba[acc]; b_i = bb[acc];
         end else begin
            in_valid_i = 1'b0;
         end
         #1;
         if (cyc == 2) rdy_c2 = in_ready_o;
         if (out_valid_o && out_ready_i) begin
            n_cmp++;
            if (c_o !== bc[got]) begin n_bad++; $display("FAIL b2b_c beat %0d got %h want %h", got, c_o, bc[got]); end
            n_cmp++;
            if ({nan_o, inf_o, ovf_o, unf_o} !== 16'h0000)
               begin n_bad++; $display("FAIL b2b_flags beat %0d got %h want 0000", got, {nan_o, inf_o, ovf_o, unf_o}); end
            got++;
         end
         if (in_valid_i && in_ready_o) acc++;
         if (cyc == 3) acc_stall = acc;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      n_cmp++;
      if (got !== 5) begin n_bad++; $display("FAIL b2b_count got %0d want 5", got); end
      n_cmp++;
      if (acc_stall !== 2) begin n_bad++; $display("FAIL b2b_stall_accepts got %0d want 2", acc_stall); end
      n_cmp++;
      if (rdy_c2 !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready_full got %b want 0", rdy_c2); end
      repeat (2) @(negedge clk_i);
      n_cmp++;
      if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_extra_beat got %b want 0", out_valid_o); end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] c; logic [15:0] f; int lat;
      @(negedge clk_i);
      out_ready_i = 1'b0; in_valid_i = 1'b1; mode_i = 1'b0;
      a_i = 32'h7C7C7C7C; b_i = 32'h00000000;
      @(negedge clk_i);
      a_i = 32'h3E3E3E3E; b_i = 32'h3E3E3E3E;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got %b want 1", out_valid_o); end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_fl_out_valid got %b want 0", out_valid_o); end
      n_cmp++;
      if ({c_o, nan_o, inf_o, ovf_o, unf_o} !== 48'd0)
         begin n_bad++; $display("FAIL rst_fl_outputs got c=%h flags=%h want 0", c_o, {nan_o, inf_o, ovf_o, unf_o}); end
      n_cmp++;
      if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_fl_in_ready got %b want 1", in_ready_o); end
      run_beat(1'b0, 32'h3C3E3C3E, 32'h3C3E3C3E, c, f, lat);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL rst_next_latency got %0d want 2", lat); end
      n_cmp++;
      if (c !== 32'h3C403C40) begin n_bad++; $display("FAIL rst_next_c got %h want 3c403c40", c); end
   endtask

   initial begin
      test_reset();
      test_e5m2_basic();
      test_specials();
      test_subnormals();
      test_e4m3();
      test_back_to_back();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
